booth_mult_n: RTL and testbench
===============================

# booth_mult_n

Parametrised sequential radix-2 Booth multiplier. It is the next generation of the 4-bit multiply stage that sits between the input capture stage and the display/result stage of the `sistema` datapath. It generalises operand width through `WIDTH` and supports both signed and unsigned operation. It replaces the one-shot `valid`/`done` pulse pair with ready/valid handshakes on both sides, and holds its result under output backpressure.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2–16.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: **synchronous, active-low** reset.
- `in_valid` input 1: operands `a`, `b` and `signed_mode` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: multiplicand.
- `b` input WIDTH: multiplier.
- `signed_mode` input 1: 1 = two's-complement operands, 0 = unsigned operands; sampled with the operands.
- `out_valid` output 1: `result` holds a finished product.
- `out_ready` input 1: consumer takes the result.
- `result` output 2*WIDTH: product, two's complement in signed mode, unsigned otherwise.
- `busy` output 1: high in CALC.

## Operation
- **Internal operand width:** `W1 = WIDTH+1`.
  - Operands are sign-extended when `signed_mode=1` and zero-extended when `signed_mode=0`.
  - After extension, M never equals -2^WIDTH, so negating M cannot overflow W1 bits.
- **Registers:**
  - `acc` (W1 bits), `q` (W1 bits), `q_m1` (1 bit), `m` (W1 bits).
  - Step counter of width `$clog2(W1+1)`.
  - `result` register (2*WIDTH bits).
- **States:** IDLE, CALC, DONE. These come from a package enum.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid`: load `m`=ext(a), `q`=ext(b), `acc`=0, `q_m1`=0, counter=W1, then go to CALC.
- **CALC, one Booth step per cycle:**
  - Examine `{q[0],q_m1}`: 01 gives acc+=m; 10 gives acc-=m; 00 and 11 leave acc unchanged.
  - Then arithmetic right shift of `{acc,q,q_m1}` by 1, and decrement the counter.
  - On the step where the counter goes 1→0, load `result` = lower 2*WIDTH bits of the shifted `{acc,q}`, then go to DONE.
- **DONE:**
  - `out_valid=1` and `result` is stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored here (`in_ready=0`).
- **Result retention:** `result` keeps its last value after leaving DONE and is overwritten only at the next completion.
- **Inputs outside IDLE:** `a`, `b` and `signed_mode` are don't-care outside the accept cycle; changing them mid-CALC has no effect.
- **Reset (`rst=0` at a clock edge), from any state including mid-CALC:**
  - state=IDLE, `acc`/`q`/`m`/`q_m1`/counter = 0, `result`=0.
  - The in-flight operation is discarded and no `out_valid` is produced for it.

## Timing
- **Reset values of outputs:** `in_ready=1`, `out_valid=0`, `busy=0`, `result=0`.
- **Accept:** occurs at clock edge E0 where `in_valid && in_ready`. `in_ready` drops and `busy` rises after E0.
- **Compute:** the steps execute at edges E1..E(W1). `out_valid` rises after edge E(W1), i.e. WIDTH+1 edges after accept (5 for WIDTH=4).
- **Output handshake:** completes at the edge where `out_valid && out_ready`. `in_ready` is high in the following cycle.
- **Throughput:** minimum accept-to-accept interval is WIDTH+3 cycles with `out_ready` tied high.
- **Backpressure:** `out_valid` and `result` hold indefinitely while `out_ready=0`.
- **`out_ready` outside DONE:** has no effect in IDLE or CALC.
- **Registered outputs:** all outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Structure
- **Package `booth_pkg`:**
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t`.
  - Helper `function` for operand extension (value, `signed_mode`) → W1 bits.
- **Sub-module `booth_step`:**
  - Parametrised by W1.
  - Purely combinational: inputs `acc`, `q`, `q_m1`, `m`; outputs the next `acc`, `q`, `q_m1` after add/sub plus arithmetic shift.
  - Instantiated once in CALC.
- **Top level:** state register, counter, operand/result registers, handshake decode.

## Test plan
- WIDTH=4, signed, a=4'b1000 (-8), b=4'b1000 (-8) → `result`=8'h40 (64), `out_valid` exactly 5 edges after accept.
- WIDTH=4, signed, a=7, b=-8 → `result`=8'hC8 (-56). Then the same bits in unsigned mode (7×8) → 8'h38.
- WIDTH=4, unsigned, a=15, b=15 → 8'hE1 (225). Then signed mode, a=4'hF, b=4'hF → 8'h01.
- Backpressure: `out_ready=0` for 6 cycles after `out_valid` while `in_valid=1` with new operands → `result` and `out_valid` are stable, `in_ready=0`, and the new operands are accepted only after the handshake.
- Reset mid-op: drive `rst=0` at the 3rd CALC step → next cycle `in_ready=1`, `out_valid=0`, `result`=0. A following 3×5 completes correctly → 8'h0F.
- WIDTH=8 instance: unsigned 255×255 → 16'hFE01; signed -128×-128 → 16'h4000, `out_valid` 9 edges after accept.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Operand extension works on a fixed 17-bit container so one function serves every WIDTH.
package booth_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

  // Extend the low 'width' bits of val to MAX_W+1 bits (sign- or zero-fill).
  function automatic logic [MAX_W:0] ext_operand(input logic [MAX_W-1:0] val,
                                                 input logic             signed_mode,
                                                 input int               width);
    logic [MAX_W:0] lo_mask;
    logic           msb;
    lo_mask = ((MAX_W + 1)'(1) << width) - (MAX_W + 1)'(1);
    msb     = |({1'b0, val} & (lo_mask ^ (lo_mask >> 1)));
    return ({1'b0, val} & lo_mask) | ({(MAX_W + 1){signed_mode & msb}} & ~lo_mask);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of m, then
// arithmetic right shift of {acc, q, q_m1}.
module booth_step #(
  parameter int W1 = 5
) (
  input  logic signed [W1-1:0] acc,
  input  logic        [W1-1:0] q,
  input  logic                 q_m1,
  input  logic signed [W1-1:0] m,
  output logic signed [W1-1:0] acc_nxt,
  output logic        [W1-1:0] q_nxt,
  output logic                 q_m1_nxt
);

  logic signed [W1-1:0] sum;

  always_comb begin
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nxt  = sum >>> 1;
    q_nxt    = {sum[0], q[W1-1:1]};
    q_m1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, with ready/valid
// handshakes on both sides; one Booth step per cycle over WIDTH+1 cycles.
module booth_mult_n
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(W1 + 1);
  localparam int RW = 2 * WIDTH;

  booth_state_t         state_q, state_d;
  logic signed [W1-1:0] acc_q, acc_d;
  logic        [W1-1:0] q_q, q_d;
  logic                 q_m1_q, q_m1_d;
  logic signed [W1-1:0] m_q, m_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic        [RW-1:0] result_q, result_d;

  logic signed [W1-1:0] acc_s;
  logic        [W1-1:0] q_s;
  logic                 q_m1_s;

  booth_step #(.W1(W1)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .q_m1     (q_m1_q),
    .m        (m_q),
    .acc_nxt  (acc_s),
    .q_nxt    (q_s),
    .q_m1_nxt (q_m1_s)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q_m1_d   = q_m1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = $signed(W1'(ext_operand(MAX_W'(a), signed_mode, WIDTH)));
          q_d     = W1'(ext_operand(MAX_W'(b), signed_mode, WIDTH));
          acc_d   = '0;
          q_m1_d  = 1'b0;
          cnt_d   = CW'(W1);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_s;
        q_d    = q_s;
        q_m1_d = q_m1_s;
        cnt_d  = cnt_q - CW'(1);
        // Last step: capture the shifted product directly, no extra cycle.
        if (cnt_q == CW'(1)) begin
          result_d = RW'({acc_s, q_s});
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      q_m1_q   <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q_m1_q   <= q_m1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_booth_mult_n.sv
// Bench for booth_mult_n: WIDTH=4 and WIDTH=8 instances, vector table plus
// hand-written backpressure / mid-operation reset sequences, scoreboard on output.
module tb_booth_mult_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] res4;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  booth_mult_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(res4), .busy(busy4)
  );

  booth_mult_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(res8), .busy(busy8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb4[$];
  logic [15:0] sb8[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference product: interpret operands per mode, keep the low 2*w bits.
  function automatic logic [15:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sm);
    longint sa, sbv, mask;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sbv  = longint'(b) & mask;
    if (sm && (((sa >> (w - 1)) & 1) == 1)) sa = sa - (longint'(1) << w);
    if (sm && (((sbv >> (w - 1)) & 1) == 1)) sbv = sbv - (longint'(1) << w);
    return 16'((sa * sbv) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb4_unexpected: result %0h with no pending operation", res4);
      end else begin
        check("res4", {24'b0, res4}, {16'b0, sb4.pop_front()});
      end
    end
    if (rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb8_unexpected: result %0h with no pending operation", res8);
      end else begin
        check("res8", {16'b0, res8}, {16'b0, sb8.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input bit w8, output int n);
    n = 0;
    while (n < 60 && !(w8 ? out_valid8 : out_valid4)) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic [15:0] exp, input int exp_lat);
    int n;
    n = 0;
    while (!(w8 ? in_ready8 : in_ready4) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("in_ready_timeout", 32'(n), 32'(0));
    if (w8) begin
      in_valid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
      sb8.push_back(exp);
    end else begin
      in_valid4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm;
      sb4.push_back(exp);
    end
    tick();
    // Scramble operands after accept; the running product must not notice.
    if (w8) begin
      in_valid8 = 1'b0; a8 = ~a[7:0]; b8 = ~b[7:0]; sm8 = ~sm;
    end else begin
      in_valid4 = 1'b0; a4 = ~a[3:0]; b4 = ~b[3:0]; sm4 = ~sm;
    end
    wait_ov(w8, n);
    check(w8 ? "lat8" : "lat4", 32'(n), 32'(exp_lat));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   seen;
    logic [15:0] ra, rb;
    logic        rs;

    vecs[0] = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[1] = '{4'h7, 4'h8, 1'b1, 8'hC8};
    vecs[2] = '{4'h7, 4'h8, 1'b0, 8'h38};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[5] = '{4'h0, 4'h5, 1'b1, 8'h00};
    vecs[6] = '{4'hF, 4'h7, 1'b1, 8'hF9};
    vecs[7] = '{4'h5, 4'hD, 1'b1, 8'hF1};

    rst = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) tick();
    rst = 1'b1;

    check("rst_in_ready4", 32'(in_ready4), 32'(1));
    check("rst_out_valid4", 32'(out_valid4), 32'(0));
    check("rst_busy4", 32'(busy4), 32'(0));
    check("rst_result4", 32'(res4), 32'(0));
    check("rst_in_ready8", 32'(in_ready8), 32'(1));
    check("rst_result8", 32'(res8), 32'(0));

    for (int i = 0; i < 8; i++)
      do_op(1'b0, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].sm, 16'(vecs[i].exp), 5);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      do_op(1'b0, ra, rb, rs, model(4, ra, rb, rs), 5);
    end

    // Backpressure: hold out_ready low with new operands already offered.
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; a4 = 4'h3; b4 = 4'hE; sm4 = 1'b1;
    sb4.push_back(16'h00FA);
    tick();
    in_valid4 = 1'b0;
    wait_ov(1'b0, n);
    check("bp_lat4", 32'(n), 32'(5));
    in_valid4 = 1'b1; a4 = 4'h2; b4 = 4'h3; sm4 = 1'b0;
    sb4.push_back(16'h0006);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid4), 32'(1));
      check("bp_result", 32'(res4), 32'(8'hFA));
      check("bp_in_ready", 32'(in_ready4), 32'(0));
    end
    out_ready4 = 1'b1;
    tick();
    check("bp_ready_after_hs", 32'(in_ready4), 32'(1));
    check("bp_not_busy_yet", 32'(busy4), 32'(0));
    tick();
    in_valid4 = 1'b0;
    check("bp_busy_after_accept", 32'(busy4), 32'(1));
    wait_ov(1'b0, n);
    check("bp_lat4_second", 32'(n), 32'(5));
    tick();

    // Reset during the third Booth step discards the operation.
    in_valid4 = 1'b1; a4 = 4'h5; b4 = 4'h5; sm4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_in_ready", 32'(in_ready4), 32'(1));
    check("midrst_out_valid", 32'(out_valid4), 32'(0));
    check("midrst_result", 32'(res4), 32'(0));
    check("midrst_busy", 32'(busy4), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid4) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'(0));
    do_op(1'b0, 16'h3, 16'h5, 1'b0, 16'h000F, 5);

    do_op(1'b1, 16'h00FF, 16'h00FF, 1'b0, 16'hFE01, 9);
    do_op(1'b1, 16'h0080, 16'h0080, 1'b1, 16'h4000, 9);
    do_op(1'b1, 16'h007F, 16'h0080, 1'b1, 16'hC080, 9);
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      do_op(1'b1, ra, rb, rs, model(8, ra, rb, rs), 9);
    end

    repeat (3) tick();
    check("sb4_drained", 32'(sb4.size()), 32'(0));
    check("sb8_drained", 32'(sb8.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
